// File: rtl/onchip_mem_loader.sv
// Byte-stream to 32-bit on-chip RAM loader (Avalon-MM master, little-endian packing).
// Optional read-back verification when ONCHIP_MEM_LOADER_VERIFY_EN is defined.
module onchip_mem_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 10240,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int SUM_W = ((LEN_W > ADDR_W) ? LEN_W : ADDR_W) + 2;

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_RD, S_CMP, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_DONE
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        lane_q, lane_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              clken_q, clken_d;

  logic [SUM_W-1:0]  nwords;
  logic [SUM_W-1:0]  end_addr;
  logic              range_bad;
  logic              last_byte;

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
  logic [31:0]       lane_mask;
  logic              verify_bad;
`else
  logic              unused_readdata;
  assign unused_readdata = ^mem_readdata;
`endif

  // A transfer ending past the last RAM word is rejected before any write.
  assign nwords    = (SUM_W'(len) + SUM_W'(3)) >> 2;
  assign end_addr  = SUM_W'(start_addr) + nwords;
  assign range_bad = end_addr > SUM_W'(DEPTH);
  assign last_byte = (lane_q == 2'd3) || (left_q == LEN_W'(1));

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
  assign lane_mask  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign verify_bad = ((mem_readdata ^ data_q) & lane_mask) != 32'd0;
`endif

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    be_d           = be_q;
    lane_d         = lane_q;
    left_d         = left_q;
    error_d        = error_q;
    busy_d         = busy_q;
    clken_d        = 1'b1;
    s_ready        = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_bad) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (len == '0) begin
            error_d = 1'b0;
            state_d = S_DONE;
          end else begin
            error_d = 1'b0;
            busy_d  = 1'b1;
            addr_d  = start_addr;
            left_d  = len;
            lane_d  = 2'd0;
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // Lane 0 starts a fresh word so unused lanes of a partial word read as zero.
          data_d = (lane_q == 2'd0) ? 32'd0 : data_q;
          data_d[{lane_q, 3'b000} +: 8] = s_data;
          left_d = left_q - LEN_W'(1);
          lane_d = lane_q + 2'd1;
          if (last_byte) begin
            case (lane_q)
              2'd0:    be_d = 4'b0001;
              2'd1:    be_d = 4'b0011;
              2'd2:    be_d = 4'b0111;
              default: be_d = 4'b1111;
            endcase
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
        state_d = S_RD;
`else
        addr_d  = addr_q + ADDR_W'(1);
        state_d = (left_q == '0) ? S_DONE : S_FILL;
`endif
      end

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
      S_RD: begin
        mem_chipselect = 1'b1;
        state_d        = S_CMP;
      end

      S_CMP: begin
        if (verify_bad) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (left_q == '0) ? S_DONE : S_FILL;
        end
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      lane_q  <= '0;
      left_q  <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      left_q  <= left_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      clken_q <= clken_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = data_q;
  assign mem_clken      = clken_q;
  assign busy           = busy_q;
  assign error          = error_q;

endmodule
